mul_arbiter: RTL
================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the multiplier; legal range 2..8.
REQ-002 Parameter DATA_W, default 32: operand and result width.
REQ-003 Parameter MUL_LAT, default 7: clock edges from operands at the multiplier inputs to the matching mul_out value.
REQ-004 Clocking and reset SHALL be one clock, with a synchronous, active-low reset: clk and rst_n.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 req_valid  input  NUM_REQ  per-requester operand valid.
REQ-008 req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
REQ-009 req_a  input  NUM_REQ*DATA_W  packed A operands; requester i at slice i.
REQ-010 req_b  input  NUM_REQ*DATA_W  packed B operands.
REQ-011 mul_a  output  DATA_W  registered A operand to the shared multiplier.
REQ-012 mul_b  output  DATA_W  registered B operand to the shared multiplier.
REQ-013 mul_out  input  DATA_W  shared multiplier result, low DATA_W bits of the product.
REQ-014 resp_valid  output  NUM_REQ  one-cycle result pulse, one-hot or zero.
REQ-015 resp_data  output  DATA_W  result; valid only while resp_valid is nonzero.
REQ-016 busy  output  1  high while any issue is in flight.

Function
REQ-017 Arbitration SHALL be round-robin: search starts at index ptr and proceeds upward with wrap, and the first requester with req_valid set is granted.
REQ-018 req_ready SHALL be combinational and equal to the grant vector; a handshake occurs where req_valid[i] and req_ready[i] are both high; at most one handshake occurs per cycle.
REQ-019 On a handshake by requester g, ptr SHALL become (g+1) mod NUM_REQ; with no handshake, ptr SHALL hold.
REQ-020 On a handshake, mul_a and mul_b SHALL register the granted operands; with no handshake, they SHALL load zero.
REQ-021 A tag pipeline of depth MUL_LAT SHALL carry {valid, requester index} for each issue, advancing every cycle with no stall.
REQ-022 For a handshake at edge E, resp_valid[g] SHALL be high exactly in the cycle after edge E+MUL_LAT, and resp_data SHALL equal mul_out in that cycle.
REQ-023 The result SHALL be the product truncated to DATA_W bits, with no overflow flag.
REQ-024 Responses SHALL have no backpressure; a response is presented for exactly one cycle.
REQ-025 Back-to-back issues, including repeated issues from the same requester on consecutive cycles when it is the only one requesting, SHALL be accepted at one per cycle.
REQ-026 busy SHALL be the OR of all tag-pipeline valid bits.

Reset
REQ-027 While rst_n is low at a clk edge, the following SHALL clear: ptr to 0, mul_a and mul_b to 0, and all tag-pipeline valid bits to 0; req_ready SHALL be 0 while rst_n is low.
REQ-028 All outputs SHALL be 0 after reset: resp_valid, resp_data, busy and req_ready.
REQ-029 A reset taken mid-operation SHALL discard every in-flight issue, and no resp_valid SHALL assert for any issue made before the reset.

Configuration
REQ-030 With macro MUL_ARBITER_PERF_EN defined, the block SHALL add outputs perf_issued (32b, handshake count) and perf_stall (32b, cycles with any req_valid high and no handshake, which occur only under reset).
REQ-031 Both perf counters SHALL saturate at all-ones and clear on reset.
REQ-032 Without MUL_ARBITER_PERF_EN, the perf ports and counters SHALL be absent.

Structure
REQ-033 Package mul_arb_pkg SHALL hold the DATA_W and MUL_LAT defaults, the requester-index typedef (clog2 of NUM_REQ bits), and the tag struct {valid, idx}.
REQ-034 The round-robin grant logic SHALL be a sub-module rr_arbiter (request vector and pointer in, one-hot grant out).

Verification
REQ-035 Requester 0 only, a=3, b=5: resp_valid[0] pulses once, 7 cycles after the handshake, with resp_data=15.
REQ-036 All 4 requesters continuously valid: grants are 0,1,2,3,0,1 on consecutive cycles, and responses return in the same order 7 cycles later.
REQ-037 Operands a=0x00010000, b=0x00010000: resp_data=0x00000000, truncated.
REQ-038 Issue 3 operations, then hold rst_n low for 1 cycle at cycle 2: no resp_valid for 10 cycles, and busy=0 after the reset edge.
REQ-039 Requester 2 valid for 5 cycles while the others are idle: 5 handshakes, 5 consecutive resp_valid[2] pulses.
REQ-040 With MUL_ARBITER_PERF_EN and 6 handshakes: perf_issued=6 and perf_stall=0.

Source files
------------

// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared defaults and types for the shared-multiplier arbiter.
//   DataWDefault / MulLatDefault : default operand width and multiplier latency
//   req_idx_t                    : requester index
//   tag_t                        : tag-pipeline entry {valid, idx}
//   onehot_to_idx()              : encode a one-hot grant into a requester index
package mul_arb_pkg;

  localparam int unsigned DataWDefault  = 32;
  localparam int unsigned MulLatDefault = 7;
  localparam int unsigned NumReqMax     = 8;

  // Sized for clog2 of the largest legal NUM_REQ so a single tag type serves
  // every legal configuration; smaller NUM_REQ simply leaves high bits zero.
  localparam int unsigned ReqIdxW = $clog2(NumReqMax);

  typedef logic [ReqIdxW-1:0] req_idx_t;

  typedef struct packed {
    logic     valid;
    req_idx_t idx;
  } tag_t;

  function automatic req_idx_t onehot_to_idx(input logic [NumReqMax-1:0] oh);
    req_idx_t idx;
    idx = '0;
    for (int unsigned i = 0; i < NumReqMax; i++) begin
      if (oh[i]) idx = idx | req_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
//   i_req : request vector
//   i_ptr : index where the search starts (wraps upward)
//   o_gnt : one-hot grant, zero when nothing is requested
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 3
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt
);

  logic [NUM_REQ-1:0] w_upper_mask;
  logic [NUM_REQ-1:0] w_req_upper;
  logic [NUM_REQ-1:0] w_pick;

  // Requests at or above the pointer take priority; otherwise wrap to the
  // lowest requester. The lowest set bit is isolated with x & -x.
  assign w_upper_mask = ~((NUM_REQ'(1) << i_ptr) - NUM_REQ'(1));
  assign w_req_upper  = i_req & w_upper_mask;
  assign w_pick       = (|w_req_upper) ? w_req_upper : i_req;
  assign o_gnt        = w_pick & (~w_pick + NUM_REQ'(1));

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin sharing of one pipelined multiplier among NUM_REQ
// requesters, with a tag pipeline routing each result back to its issuer.
//   clk, rst_n             : clock, synchronous active-low reset
//   req_valid / req_ready  : per-requester handshake (ready = grant)
//   req_a / req_b          : packed operands, requester i at slice i
//   mul_a / mul_b          : registered operands to the external multiplier
//   mul_out                : multiplier result, MUL_LAT edges after mul_a/mul_b
//   resp_valid / resp_data : one-cycle one-hot result pulse and its data
//   busy                   : any issue in flight in the tag pipeline
// Optional (macro MUL_ARBITER_PERF_EN): perf_issued, perf_stall saturating
// 32-bit counters.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = DataWDefault,
  parameter int unsigned MUL_LAT = MulLatDefault
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [DATA_W-1:0]         mul_a,
  output logic [DATA_W-1:0]         mul_b,
  input  logic [DATA_W-1:0]         mul_out,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      busy
`ifdef MUL_ARBITER_PERF_EN
  ,
  output logic [31:0]               perf_issued,
  output logic [31:0]               perf_stall
`endif
);

  logic [NUM_REQ-1:0]   w_gnt;
  logic [NUM_REQ-1:0]   w_hs;
  logic                 w_hs_any;
  logic [NumReqMax-1:0] w_hs_ext;
  req_idx_t             w_idx;
  req_idx_t             w_ptr_nxt;
  logic [DATA_W-1:0]    w_a;
  logic [DATA_W-1:0]    w_b;
  logic [NUM_REQ-1:0]   w_resp_dec;

  req_idx_t             r_ptr;
  logic [DATA_W-1:0]    r_mul_a;
  logic [DATA_W-1:0]    r_mul_b;
  tag_t                 r_tag [MUL_LAT];
  logic [NUM_REQ-1:0]   r_resp_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (ReqIdxW)
  ) u_rr_arbiter (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  // No grants are offered while reset is asserted.
  assign req_ready = rst_n ? w_gnt : '0;
  assign w_hs      = req_valid & req_ready;
  assign w_hs_any  = |w_hs;
  assign w_hs_ext  = NumReqMax'(w_hs);
  assign w_idx     = onehot_to_idx(w_hs_ext);
  assign w_ptr_nxt = (w_idx == req_idx_t'(NUM_REQ - 1)) ? '0 : w_idx + req_idx_t'(1);

  // One-hot AND-OR operand mux; yields zero when there is no handshake.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_hs[i]) begin
        w_a = w_a | req_a[i*DATA_W +: DATA_W];
        w_b = w_b | req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_resp_dec = '0;
    if (r_tag[MUL_LAT-1].valid) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        w_resp_dec[i] = (r_tag[MUL_LAT-1].idx == req_idx_t'(i));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr        <= '0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_resp_valid <= '0;
      for (int k = 0; k < int'(MUL_LAT); k++) r_tag[k] <= '0;
    end else begin
      if (w_hs_any) r_ptr <= w_ptr_nxt;
      r_mul_a      <= w_a;
      r_mul_b      <= w_b;
      r_tag[0]     <= '{valid: w_hs_any, idx: w_idx};
      for (int k = 1; k < int'(MUL_LAT); k++) r_tag[k] <= r_tag[k-1];
      // Last tag stage lines up with mul_out one edge later.
      r_resp_valid <= w_resp_dec;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < int'(MUL_LAT); k++) busy = busy | r_tag[k].valid;
  end

  assign mul_a      = r_mul_a;
  assign mul_b      = r_mul_b;
  assign resp_valid = r_resp_valid;
  assign resp_data  = (|r_resp_valid) ? mul_out : '0;

`ifdef MUL_ARBITER_PERF_EN
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_stall;
  logic        w_stall;

  // Only reachable while reset is held, where the clear takes precedence.
  assign w_stall = (|req_valid) && !w_hs_any;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_issued <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_hs_any && (r_perf_issued != '1)) r_perf_issued <= r_perf_issued + 32'd1;
      if (w_stall && (r_perf_stall != '1))   r_perf_stall  <= r_perf_stall + 32'd1;
    end
  end

  assign perf_issued = r_perf_issued;
  assign perf_stall  = r_perf_stall;
`endif

endmodule
